// File: rtl/relu_result_collector_if.sv
// Handshake bundle between a ReLU cell, the collector and the next layer.
// The collector sits on the slave side; producer/consumer on master.
interface relu_result_collector_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] input_index;
  logic [DATA_WIDTH-1:0] input_value;
  logic                  input_enable;
  logic [DATA_WIDTH:0]   output_result;
  logic                  output_ready;

  modport master (
    output input_index,
    output input_value,
    output input_enable,
    output output_ready,
    input  output_result
  );

  modport slave (
    input  input_index,
    input  input_value,
    input  input_enable,
    input  output_ready,
    output output_result
  );
endinterface

// File: rtl/relu_result_collector.sv
// Regroups ReLU samples into double-buffered activation vectors.
// Optional index checking enabled by RELU_COLLECTOR_INDEX_CHECK_EN.
module relu_result_collector #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHT_AMOUNT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  relu_result_collector_if.slave bus,
  output logic                   overflow,
  output logic                   index_error
);
  localparam int CW =
    (WEIGHT_AMOUNT > 1) ? $clog2(WEIGHT_AMOUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(WEIGHT_AMOUNT - 1);

  logic [DATA_WIDTH-1:0] r_bank [2][WEIGHT_AMOUNT];
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [CW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_rd_cnt;
  logic                  r_overflow;
  logic                  r_index_error;

  logic                  w_wr_acc;
  logic                  w_wr_done;
  logic                  w_drop;
  logic                  w_valid;
  logic                  w_xfer;
  logic                  w_rd_done;
  logic                  w_idx_err;
  logic [1:0]            w_full_nxt;

  assign w_wr_acc  = bus.input_enable && !r_full[r_wr_bank];
  assign w_drop    = bus.input_enable && r_full[r_wr_bank];
  assign w_wr_done = w_wr_acc && (r_wr_cnt == LAST);
  assign w_valid   = r_full[r_rd_bank];
  assign w_xfer    = w_valid && bus.output_ready;
  assign w_rd_done = w_xfer && (r_rd_cnt == LAST);

`ifdef RELU_COLLECTOR_INDEX_CHECK_EN
  assign w_idx_err = w_wr_acc &&
    (bus.input_index != DATA_WIDTH'(r_wr_cnt));
`else
  logic w_unused_idx;
  assign w_unused_idx = ^bus.input_index;
  assign w_idx_err    = 1'b0;
`endif

  // Write completion and read completion never target the same bank
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full        <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_overflow    <= 1'b0;
      r_index_error <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_acc) begin
        if (w_wr_done) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= r_wr_cnt + 1'b1;
        end
      end
      if (w_xfer) begin
        if (w_rd_done) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_cnt  <= r_rd_cnt + 1'b1;
        end
      end
      if (w_drop)    r_overflow    <= 1'b1;
      if (w_idx_err) r_index_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int e = 0; e < WEIGHT_AMOUNT; e++)
          r_bank[b][e] <= '0;
    end else if (w_wr_acc) begin
      r_bank[r_wr_bank][r_wr_cnt] <= bus.input_value;
    end
  end

  assign bus.output_result = w_valid ?
    {1'b1, r_bank[r_rd_bank][r_rd_cnt]} : '0;
  assign overflow    = r_overflow;
  assign index_error = r_index_error;
endmodule

// File: tb/tb_relu_result_collector.sv
// Randomized and directed bench for relu_result_collector.
// Reference model holds vectors as plain queues.
module tb_relu_result_collector;
  localparam int DW = 32;
  localparam int WA = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic overflow;
  logic index_error;

  relu_result_collector_if #(.DATA_WIDTH(DW)) bus ();

  relu_result_collector #(
    .DATA_WIDTH   (DW),
    .WEIGHT_AMOUNT(WA)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .overflow   (overflow),
    .index_error(index_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  logic [DW-1:0] m_out[$];
  logic [DW-1:0] m_part[$];
  int            m_nvec;
  int            m_pos;
  logic          m_ovf;
  logic          m_ierr;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] exp_result();
    if (m_nvec > 0) return {1'b1, m_out[0]};
    return '0;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".result"}, 64'(bus.output_result), 64'(exp_result()));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".ierr"}, 64'(index_error), 64'(m_ierr));
  endtask

  task automatic model_clear();
    m_out.delete();
    m_part.delete();
    m_nvec = 0;
    m_pos  = 0;
    m_ovf  = 1'b0;
    m_ierr = 1'b0;
  endtask

  task automatic step(input string tag,
                      input logic en,
                      input logic [DW-1:0] idx,
                      input logic [DW-1:0] val,
                      input logic rdy);
    bit xfer;
    bit drop;
    bus.input_enable = en;
    bus.input_index  = idx;
    bus.input_value  = val;
    bus.output_ready = rdy;
    xfer = (m_nvec > 0) && rdy;
    drop = en && (m_nvec == 2);
    @(posedge clk);
    if (xfer) begin
      void'(m_out.pop_front());
      m_pos++;
      if (m_pos == WA) begin
        m_pos = 0;
        m_nvec--;
      end
    end
    if (drop) m_ovf = 1'b1;
    if (en && !drop) begin
`ifdef RELU_COLLECTOR_INDEX_CHECK_EN
      if (idx != DW'(m_part.size())) m_ierr = 1'b1;
`endif
      m_part.push_back(val);
      if (m_part.size() == WA) begin
        foreach (m_part[k]) m_out.push_back(m_part[k]);
        m_part.delete();
        m_nvec++;
      end
    end
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic rst_pulse(input string tag);
    bus.input_enable = 1'b0;
    bus.output_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk({tag, ".result"}, 64'(bus.output_result), 64'h0);
    chk({tag, ".ovf"}, 64'(overflow), 64'h0);
    chk({tag, ".ierr"}, 64'(index_error), 64'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.input_enable = 1'b0;
    bus.input_index  = '0;
    bus.input_value  = '0;
    bus.output_ready = 1'b0;
    model_clear();
    #3;
    chk("por.result", 64'(bus.output_result), 64'h0);
    chk("por.ovf", 64'(overflow), 64'h0);
    chk("por.ierr", 64'(index_error), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single vector, ready high
    step("sv0", 1'b1, 0, 7, 1'b1);
    step("sv1", 1'b1, 1, 0, 1'b1);
    chk("sv.first", 64'(bus.output_result), {31'h0, 1'b1, 32'd7});
    step("sv2", 1'b0, 0, 0, 1'b1);
    step("sv3", 1'b0, 0, 0, 1'b1);
    chk("sv.empty", 64'(bus.output_result), 64'h0);

    // back-pressure
    step("bp0", 1'b1, 0, 5, 1'b0);
    step("bp1", 1'b1, 1, 9, 1'b0);
    for (int i = 0; i < 3; i++) step("bphold", 1'b0, 0, 0, 1'b0);
    chk("bp.held", 64'(bus.output_result), {31'h0, 1'b1, 32'd5});
    step("bp2", 1'b0, 0, 0, 1'b1);
    chk("bp.second", 64'(bus.output_result), {31'h0, 1'b1, 32'd9});
    step("bp3", 1'b0, 0, 0, 1'b1);

    // overflow: 5 samples with ready low
    for (int i = 0; i < 5; i++)
      step("of", 1'b1, DW'(i % 2), DW'(i + 1), 1'b0);
    chk("of.flag", 64'(overflow), 64'h1);
    for (int i = 0; i < 5; i++) step("ofdrain", 1'b0, 0, 0, 1'b1);
    chk("of.empty", 64'(bus.output_result), 64'h0);

    rst_pulse("rst1");

    // index check: indices 0,0
    step("ix0", 1'b1, 0, 3, 1'b1);
    step("ix1", 1'b1, 0, 6, 1'b1);
    step("ix2", 1'b0, 0, 0, 1'b1);
    step("ix3", 1'b0, 0, 0, 1'b1);

    // reset mid-drain
    step("md0", 1'b1, 0, 1, 1'b1);
    step("md1", 1'b1, 1, 2, 1'b1);
    step("md2", 1'b0, 0, 0, 1'b1);
    rst_pulse("rst2");
    step("fr0", 1'b1, 0, 8, 1'b1);
    step("fr1", 1'b1, 1, 4, 1'b1);
    chk("fr.first", 64'(bus.output_result), {31'h0, 1'b1, 32'd8});
    step("fr2", 1'b0, 0, 0, 1'b1);
    chk("fr.second", 64'(bus.output_result), {31'h0, 1'b1, 32'd4});
    step("fr3", 1'b0, 0, 0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] idx;
      idx = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(0, 3))
                                        : DW'(m_part.size());
      step("rnd", 1'($urandom_range(0, 1)), idx, DW'($urandom),
           1'($urandom_range(0, 2) != 0));
      if (i == 200) rst_pulse("rstr");
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
